fcounter_seq: RTL and testbench

//  Initiator side of the fcounter measurement handshake. On a start request it runs
//  cfg_nmeas back-to-back measurements: drives fcounter_ce and fcounter_som, waits for

---
 rtl/fcounter_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fcounter_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcounter_seq.sv
// Initiator for the fcounter measurement handshake: runs cfg_nmeas measurements
// per start request and reports count, sum, min and max of the captured samples.
module fcounter_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4,
  parameter int unsigned TW = 16
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   cfg_nmeas,
  input  logic [TW-1:0]   cfg_timeout,
  output logic            fcounter_ce,
  output logic            fcounter_som,
  input  logic            fcounter_eom,
  input  logic            fcounter_rdy,
  input  logic [N-1:0]    fcounter_adata,
  output logic            busy,
  output logic            done,
  output logic            err_timeout,
  output logic            err_abort,
  output logic [CW-1:0]   res_count,
  output logic [N+CW-1:0] res_sum,
  output logic [N-1:0]    res_min,
  output logic [N-1:0]    res_max
);

  localparam int unsigned SW = N + CW;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_SOM      = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_WAIT_EOM = 3'd4,
    S_CAPTURE  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] nmeas_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] wd_q;

  logic          accept;
  logic          capture;
  logic          wd_clr;
  logic          set_tmo;
  logic          set_abort;
  logic          wd_hit;
  logic [CW-1:0] count_inc;

  assign wd_hit    = (tmo_q != '0) && (wd_q == tmo_q);
  assign count_inc = res_count + CW'(1);

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort outranks capture and watchdog in every busy state but DONE
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    wd_clr    = 1'b0;
    set_tmo   = 1'b0;
    set_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          wd_clr  = 1'b1;
          state_d = (cfg_nmeas == '0) ? S_DONE : S_WAIT_RDY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        if (abort) begin
          set_abort = 1'b1;
          state_d   = S_DONE;
        end else begin
          case (state_q)
            S_WAIT_RDY: begin
              if (fcounter_rdy && fcounter_eom) begin
                state_d = S_SOM;
              end else if (wd_hit) begin
                set_tmo = 1'b1;
                state_d = S_DONE;
              end
            end
            S_SOM: begin
              wd_clr  = 1'b1;
              state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
              if (!fcounter_eom) begin
                wd_clr  = 1'b1;
                state_d = S_WAIT_EOM;
              end else if (wd_hit) begin
                set_tmo = 1'b1;
                state_d = S_DONE;
              end
            end
            S_WAIT_EOM: begin
              if (fcounter_eom) begin
                state_d = S_CAPTURE;
              end else if (wd_hit) begin
                set_tmo = 1'b1;
                state_d = S_DONE;
              end
            end
            S_CAPTURE: begin
              capture = 1'b1;
              state_d = (count_inc == nmeas_q) ? S_DONE : S_SOM;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Watchdog reads 1 in the first cycle of each wait state, so it fires on cycle cfg_timeout
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wd_q <= '0;
    end else if (wd_clr) begin
      wd_q <= TW'(1);
    end else begin
      wd_q <= wd_q + TW'(1);
    end
  end

  // Run configuration, latched on an accepted start
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      nmeas_q <= '0;
      tmo_q   <= '0;
    end else if (accept) begin
      nmeas_q <= cfg_nmeas;
      tmo_q   <= cfg_timeout;
    end
  end

  // Result accumulation and sticky error flags
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      res_count   <= '0;
      res_sum     <= '0;
      res_min     <= '0;
      res_max     <= '0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
    end else if (accept) begin
      res_count   <= '0;
      res_sum     <= '0;
      res_min     <= '0;
      res_max     <= '0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      if (capture) begin
        res_count <= count_inc;
        res_sum   <= res_sum + SW'(fcounter_adata);
        if (res_count == '0) begin
          res_min <= fcounter_adata;
          res_max <= fcounter_adata;
        end else begin
          if (fcounter_adata < res_min) res_min <= fcounter_adata;
          if (fcounter_adata > res_max) res_max <= fcounter_adata;
        end
      end
      if (set_tmo)   err_timeout <= 1'b1;
      if (set_abort) err_abort   <= 1'b1;
    end
  end

  // Registered handshake/status outputs decoded from the next state
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fcounter_ce  <= 1'b0;
      fcounter_som <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      fcounter_ce  <= (state_d != S_IDLE) && (state_d != S_DONE);
      fcounter_som <= (state_d == S_SOM);
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_fcounter_seq.sv
// Directed bench for fcounter_seq with a behavioural fcounter responder.
module tb_fcounter_seq;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;

  logic            clk = 1'b0;
  logic            rstb;
  logic            start;
  logic            abort;
  logic [CW-1:0]   cfg_nmeas;
  logic [TW-1:0]   cfg_timeout;
  logic            fcounter_ce;
  logic            fcounter_som;
  logic            fcounter_eom;
  logic            fcounter_rdy;
  logic [N-1:0]    fcounter_adata;
  logic            busy;
  logic            done;
  logic            err_timeout;
  logic            err_abort;
  logic [CW-1:0]   res_count;
  logic [N+CW-1:0] res_sum;
  logic [N-1:0]    res_min;
  logic [N-1:0]    res_max;

  fcounter_seq #(.N(N), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .cfg_nmeas(cfg_nmeas), .cfg_timeout(cfg_timeout),
    .fcounter_ce(fcounter_ce), .fcounter_som(fcounter_som),
    .fcounter_eom(fcounter_eom), .fcounter_rdy(fcounter_rdy),
    .fcounter_adata(fcounter_adata), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_abort(err_abort),
    .res_count(res_count), .res_sum(res_sum), .res_min(res_min), .res_max(res_max)
  );

  always #5 clk = ~clk;

  // Responder controls (written by the stimulus) and observations (written by the model)
  logic [N-1:0] samples [0:7];
  int  delay;
  bit  hang;
  bit  clr;
  int  idx, low, cyc, som_cnt, done_cnt, drop_cyc, done_cyc;
  bit  pend;
  int  vectors = 0;
  int  fails   = 0;

  // fcounter model: eom drops one cycle after som, rises about `delay` cycles later with the next sample
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr) begin
      fcounter_eom   = 1'b1;
      fcounter_adata = '0;
      idx = 0; low = 0; pend = 1'b0; som_cnt = 0; done_cnt = 0;
    end else begin
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (pend) begin
        pend = 1'b0;
        fcounter_eom = 1'b0;
        low = delay;
        drop_cyc = cyc;
      end else if (!fcounter_eom && !hang) begin
        if (low <= 1) begin
          fcounter_adata = samples[idx];
          idx = idx + 1;
          fcounter_eom = 1'b1;
        end else begin
          low = low - 1;
        end
      end
      if (fcounter_som) begin
        som_cnt = som_cnt + 1;
        pend = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic run_start(input logic [CW-1:0] n, input logic [TW-1:0] t);
    cfg_nmeas   = n;
    cfg_timeout = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int  k;
    bit  reached;
    cyc = 0; drop_cyc = 0; done_cyc = 0;
    rstb = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_nmeas = '0; cfg_timeout = '0; fcounter_rdy = 1'b1;
    hang = 1'b0; delay = 20; clr = 1'b1;
    for (int i = 0; i < 8; i++) samples[i] = '0;
    tick(); tick();
    check("rst_ce",   32'(fcounter_ce), 32'd0);
    check("rst_som",  32'(fcounter_som), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_errs", 32'({err_timeout, err_abort}), 32'd0);
    check("rst_res",  32'(res_count) | 32'(res_sum) | 32'(res_min) | 32'(res_max), 32'd0);
    rstb = 1'b1;
    tick();
    clr = 1'b0;

    // 1: single measurement, rdy held low at first
    samples[0] = 8'h5A; delay = 20; fcounter_rdy = 1'b0;
    run_start(4'd1, 16'd0);
    tick(); tick(); tick();
    check("t1_rdy_hold_som", 32'(som_cnt), 32'd0);
    check("t1_busy_ce", 32'({busy, fcounter_ce}), 32'd3);
    fcounter_rdy = 1'b1;
    wait_done("t1_done", 200);
    check("t1_som_cnt", 32'(som_cnt), 32'd1);
    check("t1_count", 32'(res_count), 32'd1);
    check("t1_sum", 32'(res_sum), 32'h05A);
    check("t1_minmax", {16'd0, res_min, res_max}, 32'h5A5A);
    check("t1_errs", 32'({err_timeout, err_abort}), 32'd0);
    check("t1_ce_at_done", 32'(fcounter_ce), 32'd0);
    tick();
    check("t1_done_pulse", 32'({done, busy, fcounter_ce}), 32'd0);

    // 2: four samples, start latency, start while busy ignored
    model_clr();
    samples[0] = 8'h10; samples[1] = 8'hF0; samples[2] = 8'h01; samples[3] = 8'h80;
    delay = 5;
    run_start(4'd4, 16'd0);
    check("t2_som_lat1", 32'(fcounter_som), 32'd0);
    tick();
    check("t2_som_lat2", 32'(fcounter_som), 32'd1);
    tick();
    check("t2_som_one_cycle", 32'(fcounter_som), 32'd0);
    tick();
    cfg_nmeas = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t2_done", 400);
    check("t2_som_cnt", 32'(som_cnt), 32'd4);
    check("t2_count", 32'(res_count), 32'd4);
    check("t2_sum", 32'(res_sum), 32'h181);
    check("t2_min", 32'(res_min), 32'h01);
    check("t2_max", 32'(res_max), 32'hF0);
    check("t2_errs", 32'({err_timeout, err_abort}), 32'd0);
    tick();

    // 3: eom never returns after first som, timeout 50
    model_clr();
    delay = 5; hang = 1'b1;
    run_start(4'd2, 16'd50);
    wait_done("t3_done", 300);
    check("t3_err_timeout", 32'(err_timeout), 32'd1);
    check("t3_err_abort", 32'(err_abort), 32'd0);
    check("t3_count", 32'(res_count), 32'd0);
    check("t3_timeout_cycles", 32'(done_cyc - drop_cyc), 32'd51);
    check("t3_som_cnt", 32'(som_cnt), 32'd1);
    tick();
    check("t3_ce_after", 32'({fcounter_ce, busy}), 32'd0);
    hang = 1'b0;

    // 4: abort during the second WAIT_EOM, then a clean rerun
    model_clr();
    samples[0] = 8'h33; samples[1] = 8'h44; samples[2] = 8'h77;
    delay = 30;
    run_start(4'd3, 16'd0);
    k = 0;
    reached = 1'b0;
    while (!reached && k < 300) begin
      tick();
      k++;
      reached = (som_cnt == 2) && (fcounter_eom == 1'b0);
    end
    check("t4_reach_eom2", 32'(reached), 32'd1);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_done_next", 32'(done), 32'd1);
    check("t4_err_abort", 32'(err_abort), 32'd1);
    check("t4_count", 32'(res_count), 32'd1);
    check("t4_sum", 32'(res_sum), 32'h033);
    check("t4_ce", 32'(fcounter_ce), 32'd0);
    repeat (40) tick();
    check("t4_no_third_som", 32'(som_cnt), 32'd2);
    run_start(4'd1, 16'd0);
    check("t4_err_cleared", 32'({err_abort, err_timeout}), 32'd0);
    check("t4_res_cleared", 32'(res_count), 32'd0);
    wait_done("t4_rerun_done", 200);
    check("t4_rerun_sum", 32'(res_sum), 32'h077);
    check("t4_rerun_min", 32'(res_min), 32'h77);
    check("t4_rerun_err", 32'(err_abort), 32'd0);
    tick();

    // 5: zero measurements
    run_start(4'd0, 16'd0);
    check("t5_done", 32'({done, busy, fcounter_ce, fcounter_som}), 32'b1100);
    check("t5_res_zero", 32'(res_count) | 32'(res_sum) | 32'(res_min) | 32'(res_max), 32'd0);
    tick();
    check("t5_idle", 32'({done, busy, fcounter_ce}), 32'd0);

    // 6: reset in WAIT_EOM, then a normal run
    model_clr();
    samples[0] = 8'hAB; delay = 40;
    run_start(4'd1, 16'd0);
    k = 0;
    while (fcounter_eom !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    check("t6_reach_eom", 32'(fcounter_eom), 32'd0);
    repeat (5) tick();
    rstb = 1'b0;
    #1;
    check("t6_rst_outs", 32'({fcounter_ce, fcounter_som, busy, done}), 32'd0);
    tick();
    check("t6_no_done", 32'(done_cnt), 32'd0);
    rstb = 1'b1;
    model_clr();
    samples[0] = 8'h99; delay = 5;
    run_start(4'd1, 16'd0);
    wait_done("t6_done", 200);
    check("t6_count", 32'(res_count), 32'd1);
    check("t6_sum", 32'(res_sum), 32'h099);
    check("t6_max", 32'(res_max), 32'h99);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
